// File: rtl/memory_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_access_stage                                                        |
// |   MEM pipeline stage: passes ALU ops through, issues valid/ready data-     |
// |   memory requests for loads/stores, stalls upstream until they complete.   |
// |   Optional misaligned-access check: define MEM_ALIGN_CHECK_EN.             |
// |   Revision: 1.0                                                            |
// +----------------------------------------------------------------------------+
module memory_access_stage #(
  parameter int WORD       = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int SRC_WIDTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  is_valid_i,
  input  logic                  mem_write_en_i,
  input  logic                  mem_read_en_i,
  input  logic                  reg_file_write_en_i,
  input  logic [SRC_WIDTH-1:0]  reg_file_data_source_i,
  input  logic [ADDR_WIDTH-1:0] reg_dest_addr_i,
  input  logic [WORD-1:0]       alu_result_i,
  input  logic [WORD-1:0]       reg_2_data_i,
  output logic                  stall_o,
  output logic                  dmem_req_valid_o,
  input  logic                  dmem_req_ready_i,
  output logic                  dmem_req_write_o,
  output logic [WORD-1:0]       dmem_addr_o,
  output logic [WORD-1:0]       dmem_wdata_o,
  input  logic                  dmem_rsp_valid_i,
  input  logic [WORD-1:0]       dmem_rdata_i,
  output logic                  is_valid_o,
  output logic                  reg_file_write_en_o,
  output logic [SRC_WIDTH-1:0]  reg_file_data_source_o,
  output logic [ADDR_WIDTH-1:0] reg_dest_addr_o,
  output logic [WORD-1:0]       alu_result_o,
  output logic [WORD-1:0]       mem_data_o,
  output logic                  fault_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_RSP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_req_valid;
  logic                  r_hold_write;
  logic                  r_hold_rf_we;
  logic [SRC_WIDTH-1:0]  r_hold_src;
  logic [ADDR_WIDTH-1:0] r_hold_dest;
  logic [WORD-1:0]       r_hold_addr;
  logic [WORD-1:0]       r_hold_wdata;
  logic                  r_valid;
  logic                  r_rf_we;
  logic [SRC_WIDTH-1:0]  r_src;
  logic [ADDR_WIDTH-1:0] r_dest;
  logic [WORD-1:0]       r_alu;
  logic [WORD-1:0]       r_mem_data;
  logic                  r_fault;
  logic                  w_memop;
  logic                  w_misaligned;
  logic                  w_issue;
  logic                  w_complete;
  logic                  w_stall;

  assign w_memop = is_valid_i & (mem_read_en_i | mem_write_en_i);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned = w_memop & (alu_result_i[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_complete   = 1'b0;
    w_stall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_memop && !w_misaligned) begin
          w_issue      = 1'b1;
          w_stall      = 1'b1;
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (dmem_req_ready_i && r_hold_write) begin
          w_complete   = 1'b1;
          w_state_next = S_IDLE;
        end else if (dmem_req_ready_i) begin
          w_stall      = 1'b1;
          w_state_next = S_WAIT_RSP;
        end else begin
          w_stall      = 1'b1;
        end
      end
      S_WAIT_RSP: begin
        if (dmem_rsp_valid_i) begin
          w_complete   = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_stall      = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= S_IDLE;
      r_req_valid  <= 1'b0;
      r_hold_write <= 1'b0;
      r_hold_rf_we <= 1'b0;
      r_hold_src   <= '0;
      r_hold_dest  <= '0;
      r_hold_addr  <= '0;
      r_hold_wdata <= '0;
    end else begin
      r_state     <= w_state_next;
      r_req_valid <= (w_state_next == S_REQ);
      // Read+write together is treated as a store
      if (w_issue) begin
        r_hold_write <= mem_write_en_i;
        r_hold_rf_we <= reg_file_write_en_i;
        r_hold_src   <= reg_file_data_source_i;
        r_hold_dest  <= reg_dest_addr_i;
        r_hold_addr  <= alu_result_i;
        r_hold_wdata <= reg_2_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_valid    <= 1'b0;
      r_rf_we    <= 1'b0;
      r_src      <= '0;
      r_dest     <= '0;
      r_alu      <= '0;
      r_mem_data <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      if (r_state == S_IDLE && !w_issue) begin
        r_valid <= is_valid_i;
        r_rf_we <= reg_file_write_en_i & ~w_misaligned;
        r_src   <= reg_file_data_source_i;
        r_dest  <= reg_dest_addr_i;
        r_alu   <= alu_result_i;
        r_fault <= w_misaligned;
      end else if (w_complete) begin
        r_valid <= 1'b1;
        r_rf_we <= r_hold_rf_we;
        r_src   <= r_hold_src;
        r_dest  <= r_hold_dest;
        r_alu   <= r_hold_addr;
        if (r_state == S_WAIT_RSP) begin
          r_mem_data <= dmem_rdata_i;
        end
      end
    end
  end

  // Stall is combinational, so it is masked while reset is asserted
  assign stall_o                = w_stall & reset_n_i;
  assign dmem_req_valid_o       = r_req_valid;
  assign dmem_req_write_o       = r_hold_write;
  assign dmem_addr_o            = r_hold_addr;
  assign dmem_wdata_o           = r_hold_wdata;
  assign is_valid_o             = r_valid;
  assign reg_file_write_en_o    = r_rf_we;
  assign reg_file_data_source_o = r_src;
  assign reg_dest_addr_o        = r_dest;
  assign alu_result_o           = r_alu;
  assign mem_data_o             = r_mem_data;
  assign fault_o                = r_fault;

endmodule
`default_nettype wire
